// File: rtl/rbv_sched_pkg.sv
// rbv_sched_pkg: shared types for the row_by_vector scheduler.
// FSM state encoding, tag field bit offsets, default datapath latency.
package rbv_sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_DONE,
    S_ZERO
  } state_t;

  localparam int DEF_LATENCY = 7;

  // Tag layout: {row, last, valid}
  localparam int TAG_VALID = 0;
  localparam int TAG_LAST  = 1;
  localparam int TAG_ROW   = 2;

endpackage

// File: rtl/rbv_tag_delay_line.sv
// rbv_tag_delay_line: DEPTH-deep tag shift register, sync clear.
// Ports: clk, reset, din[WIDTH], dout[WIDTH], any_valid (OR of VALID_BIT).
module rbv_tag_delay_line #(
  parameter int WIDTH     = 12,
  parameter int DEPTH     = 7,
  parameter int VALID_BIT = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             any_valid
);

  logic [WIDTH-1:0] pipe [DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++)
        pipe[i] <= '0;
    end else begin
      pipe[0] <= din;
      for (int i = 1; i < DEPTH; i++)
        pipe[i] <= pipe[i-1];
    end
  end

  always_comb begin
    any_valid = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      any_valid = any_valid | pipe[i][VALID_BIT];
  end

  assign dout = pipe[DEPTH-1];

endmodule

// File: rtl/row_by_vector_scheduler.sv
// row_by_vector_scheduler: walks rows x chunks, issues operand reads and
// datapath starts, and tags each result with its row and last-chunk flag.
// Ports: clk, reset, start, num_rows, num_multiples, mem_ready ->
//   mem_rd_en, mem_addr, dp_start, res_valid, res_row, res_last, busy,
//   done, stall_cnt (only with RBV_SCHED_STALL_CNT_EN defined).
module row_by_vector_scheduler
  import rbv_sched_pkg::*;
#(
  parameter int ROW_W   = 10,
  parameter int MULT_W  = 6,
  parameter int ADDR_W  = 16,
  parameter int LATENCY = DEF_LATENCY
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ROW_W-1:0]  num_rows,
  input  logic [MULT_W-1:0] num_multiples,
  input  logic              mem_ready,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              dp_start,
  output logic              res_valid,
  output logic [ROW_W-1:0]  res_row,
  output logic              res_last,
  output logic              busy,
  output logic              done
`ifdef RBV_SCHED_STALL_CNT_EN
  ,
  output logic [31:0]       stall_cnt
`endif
);

  localparam int TW = ROW_W + TAG_ROW;

  state_t            state, state_nx;
  logic [ROW_W-1:0]  rows_q, row;
  logic [MULT_W-1:0] mults_q, chunk;
  logic [ADDR_W-1:0] addr;
  logic              issue, go;
  logic              chunk_end, row_end;
  logic              pipe_busy;
  logic [TW-1:0]     tag_in, tag_out;

  assign chunk_end = (chunk == mults_q - MULT_W'(1));
  assign row_end   = (row == rows_q - ROW_W'(1));
  assign go        = (state == S_IDLE) && start;

  always_comb begin
    state_nx = state;
    issue    = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          if (num_rows != '0 && num_multiples != '0)
            state_nx = S_ISSUE;
          else
            state_nx = S_ZERO;
        end
      end
      S_ISSUE: begin
        busy  = 1'b1;
        issue = mem_ready;
        if (mem_ready && chunk_end && row_end)
          state_nx = S_DRAIN;
      end
      S_DRAIN: begin
        busy = 1'b1;
        if (!pipe_busy)
          state_nx = S_DONE;
      end
      S_DONE, S_ZERO: begin
        done     = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      rows_q  <= '0;
      mults_q <= '0;
      row     <= '0;
      chunk   <= '0;
      addr    <= '0;
    end else begin
      state <= state_nx;
      if (go) begin
        rows_q  <= num_rows;
        mults_q <= num_multiples;
        row     <= '0;
        chunk   <= '0;
        addr    <= '0;
      end else if (issue) begin
        // running address avoids a row*num_multiples multiplier
        addr <= addr + ADDR_W'(1);
        if (chunk_end) begin
          chunk <= '0;
          row   <= row + ROW_W'(1);
        end else begin
          chunk <= chunk + MULT_W'(1);
        end
      end
    end
  end

  assign tag_in = issue ? {row, chunk_end, 1'b1} : '0;

  rbv_tag_delay_line #(
    .WIDTH     (TW),
    .DEPTH     (LATENCY),
    .VALID_BIT (TAG_VALID)
  ) u_tags (
    .clk       (clk),
    .reset     (reset),
    .din       (tag_in),
    .dout      (tag_out),
    .any_valid (pipe_busy)
  );

  assign mem_rd_en = issue;
  assign dp_start  = issue;
  assign mem_addr  = addr;
  assign res_valid = tag_out[TAG_VALID];
  assign res_last  = tag_out[TAG_LAST];
  assign res_row   = tag_out[TAG_ROW +: ROW_W];

`ifdef RBV_SCHED_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (reset || go)
      stall_cnt <= '0;
    else if (state == S_ISSUE && !mem_ready && stall_cnt != '1)
      stall_cnt <= stall_cnt + 32'd1;
  end
`endif

endmodule

// File: tb/tb_row_by_vector_scheduler.sv
// tb_row_by_vector_scheduler: directed jobs against row_by_vector_scheduler.
// Checks issue order, addresses, result tags, latency, done and reset.
module tb_row_by_vector_scheduler;

  localparam int LAT = 7;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [9:0]  num_rows = '0;
  logic [5:0]  num_multiples = '0;
  logic        mem_ready = 1'b1;
  logic        mem_rd_en;
  logic [15:0] mem_addr;
  logic        dp_start;
  logic        res_valid;
  logic [9:0]  res_row;
  logic        res_last;
  logic        busy;
  logic        done;
`ifdef RBV_SCHED_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  row_by_vector_scheduler dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .num_rows      (num_rows),
    .num_multiples (num_multiples),
    .mem_ready     (mem_ready),
    .mem_rd_en     (mem_rd_en),
    .mem_addr      (mem_addr),
    .dp_start      (dp_start),
    .res_valid     (res_valid),
    .res_row       (res_row),
    .res_last      (res_last),
    .busy          (busy),
    .done          (done)
`ifdef RBV_SCHED_STALL_CNT_EN
    ,
    .stall_cnt     (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int done_cnt = 0;
  int dp_mis  = 0;
  int iss_addr [$];
  int iss_cyc  [$];
  int r_row    [$];
  int r_last   [$];
  int r_cyc    [$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!reset) begin
      if (mem_rd_en) begin
        iss_addr.push_back(int'(mem_addr));
        iss_cyc.push_back(cyc);
      end
      if (mem_rd_en !== dp_start) dp_mis++;
      if (res_valid) begin
        r_row.push_back(int'(res_row));
        r_last.push_back(int'(res_last));
        r_cyc.push_back(cyc);
      end
      if (done) done_cnt++;
    end
  end

  task automatic check(string tag, int got, int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    iss_addr.delete();
    iss_cyc.delete();
    r_row.delete();
    r_last.delete();
    r_cyc.delete();
    dp_mis = 0;
  endtask

  task automatic run_job(int rows, int mults, int st_lo, int st_hi,
                         bit poke);
    int  d0;
    int  total;
    bit  seen;
    bit  zero;
    zero = (rows == 0) || (mults == 0);
    clear_log();
    d0 = done_cnt;
    num_rows = 10'(rows);
    num_multiples = 6'(mults);
    mem_ready = 1'b1;
    start = 1'b1;
    step();
    seen = 1'b0;
    for (int k = 0; k < 300; k++) begin
      mem_ready = !(k >= st_lo && k <= st_hi);
      if (poke && k == 2) begin
        start = 1'b1;
        num_rows = 10'd7;
      end else begin
        start = 1'b0;
      end
      if (k == 0 && !zero) check("busy_first", int'(busy), 1);
      if (done) begin
        seen = 1'b1;
        check("busy_at_done", int'(busy), 0);
        if (zero) check("zero_done_lat", k, 0);
        break;
      end
      step();
    end
    start = 1'b0;
    mem_ready = 1'b1;
    check("done_seen", int'(seen), 1);
    repeat (3) step();
    total = rows * mults;
    check("done_count", done_cnt - d0, 1);
    check("issue_count", iss_addr.size(), total);
    check("result_count", r_row.size(), total);
    check("dp_start_eq_rd", dp_mis, 0);
    for (int j = 0; j < total; j++) begin
      if (j < iss_addr.size()) check("addr", iss_addr[j], j);
      if (j < r_row.size()) begin
        check("res_row", r_row[j], j / mults);
        check("res_last", r_last[j], int'((j % mults) == mults - 1));
        if (j < iss_cyc.size())
          check("latency", r_cyc[j] - iss_cyc[j], LAT);
      end
    end
  endtask

  initial begin
    int d0;
    reset = 1'b1;
    repeat (3) step();
    check("rst_rd_en", int'(mem_rd_en), 0);
    check("rst_dp_start", int'(dp_start), 0);
    check("rst_addr", int'(mem_addr), 0);
    check("rst_res_valid", int'(res_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
`ifdef RBV_SCHED_STALL_CNT_EN
    check("rst_stall_cnt", int'(stall_cnt), 0);
`endif
    reset = 1'b0;
    step();

    run_job(4, 1, -1, -2, 1'b0);
    run_job(2, 3, -1, -2, 1'b0);
    run_job(2, 3, 2, 4, 1'b0);
`ifdef RBV_SCHED_STALL_CNT_EN
    check("stall_cnt", int'(stall_cnt), 3);
`endif
    run_job(0, 3, -1, -2, 1'b0);
    run_job(2, 0, -1, -2, 1'b0);

    num_rows = 10'd4;
    num_multiples = 6'd3;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (3) step();
    reset = 1'b1;
    step();
    check("mid_rd_en", int'(mem_rd_en), 0);
    check("mid_dp_start", int'(dp_start), 0);
    check("mid_addr", int'(mem_addr), 0);
    check("mid_res_valid", int'(res_valid), 0);
    check("mid_res_row", int'(res_row), 0);
    check("mid_res_last", int'(res_last), 0);
    check("mid_busy", int'(busy), 0);
    check("mid_done", int'(done), 0);
    reset = 1'b0;
    clear_log();
    d0 = done_cnt;
    repeat (15) step();
    check("post_rst_res", r_row.size(), 0);
    check("post_rst_issue", iss_addr.size(), 0);
    check("post_rst_done", done_cnt - d0, 0);
    run_job(1, 2, -1, -2, 1'b0);

    run_job(3, 2, -1, -2, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
